dff_pipe: RTL

- Parametrised, elastic register pipeline. It is the next-generation successor of the single-bit edge-triggered D flip-flop cell.
- Generalised in data width and stage count. Adds per-stage valid tracking, valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between synthesised datapath blocks wherever retiming stages with flow control are needed.

---
 rtl/dff_pipe_pkg.sv | 12 +
 rtl/dff_pipe_stage.sv | 31 +++
 rtl/dff_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic register pipeline.
package dff_pipe_pkg;

  localparam logic DATA_RST  = 1'b0;
  localparam logic VALID_RST = 1'b0;

  // Bits needed to count 0..n inclusive.
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: data register plus valid bit, advancing when the
// downstream ready chain allows it.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic             flush,
  input  logic             rdy,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge C) begin
    if (!RN) begin
      v <= VALID_RST;
      d <= {WIDTH{DATA_RST}};
    end else if (flush) begin
      v <= 1'b0;
    end else if (rdy) begin
      v <= prev_v;
      // Data only moves with a valid word so an emptied stage keeps its last value.
      if (prev_v) d <= prev_d;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = clog2_p1(DEPTH)
) (
  input  logic             C,
  input  logic             RN,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic [OCC_W-1:0] OCC
);

  // Handshake: a word transfers on a rising C edge where valid & ready are both
  // high; valid never waits on ready, while ready may depend on valid/Q_READY.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  // A stage can take a word if it is empty or everything after it can move.
  always_comb begin
    logic r;
    r = ~v[DEPTH-1] | Q_READY;
    rdy[DEPTH-1] = r;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r = ~v[i] | r;
      rdy[i] = r;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (i == 0) begin : g_in
      assign pv = D_VALID;
      assign pd = D;
    end else begin : g_mid
      assign pv = v[i-1];
      assign pd = d[i-1];
    end
    dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .C      (C),
      .RN     (RN),
      .flush  (FLUSH),
      .rdy    (rdy[i]),
      .prev_v (pv),
      .prev_d (pd),
      .v      (v[i]),
      .d      (d[i])
    );
  end

  assign D_READY  = rdy[0] & ~FLUSH;
  assign Q        = d[DEPTH-1];
  assign Q_VALID  = v[DEPTH-1] & ~FLUSH;
  assign in_xfer  = D_VALID & D_READY;
  assign out_xfer = Q_VALID & Q_READY;

  always_ff @(posedge C) begin
    if (!RN) begin
      occ_q <= '0;
    end else if (FLUSH) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  assign OCC = occ_q;

endmodule
